// File: rtl/tcd1304_pkg.sv
// Shared types and constants for the TCD1304 linear-CCD timing generator.
package tcd1304_pkg;

    localparam int PER_W  = 20;
    localparam int DIV_W  = 8;
    localparam int PROD_W = PER_W + DIV_W;

    localparam int DEF_CLK_DIV   = 50;
    localparam int DEF_SH_WIDTH  = 4;
    localparam int DEF_ICG_LEAD  = 1;
    localparam int DEF_ICG_TRAIL = 2;
    localparam int MIN_FRAME     = 14776;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic [PER_W-1:0] period;
        logic [DIV_W-1:0] icg_div;
        logic [1:0]       phase;
    } cfg_t;

endpackage

// File: rtl/tcd1304_fm_div.sv
// fM divider: clk_2m is a registered 50% clock, fm_tick marks the last system clock of each fM period.
module tcd1304_fm_div
    import tcd1304_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic clk_2m,
    output logic fm_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    assign fm_tick = (div_cnt == CW'(CLK_DIV - 1));
    assign div_nxt = fm_tick ? '0 : div_cnt + CW'(1);

    // clk_2m is derived from the next count so its rising edge lands on the edge after fm_tick
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            clk_2m  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            clk_2m  <= (div_nxt < CW'(CLK_DIV / 2));
        end
    end

endmodule

// File: rtl/tcd1304_timing_gen.sv
// TCD1304 SH/ICG sequencer with frame-boundary config apply and downstream load/phase handoff.
module tcd1304_timing_gen
    import tcd1304_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int SH_WIDTH  = DEF_SH_WIDTH,
    parameter int ICG_LEAD  = DEF_ICG_LEAD,
    parameter int ICG_TRAIL = DEF_ICG_TRAIL,
    parameter int MIN_FRAME = tcd1304_pkg::MIN_FRAME
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] cfg_sh_period,
    input  logic [DIV_W-1:0] cfg_icg_div,
    input  logic [1:0]       cfg_sync_phase,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_2m,
    output logic             tcd1304_sh,
    output logic             tcd1304_icg,
    output logic             tcd1304_load,
    output logic [1:0]       sync_phase,
    output logic             frame_start
);

    localparam int MIN_PER = SH_WIDTH + ICG_LEAD + ICG_TRAIL + 1;

    logic             fm_tick;
    state_e           state;
    cfg_t             pend;
    logic             pend_vld;
    logic [PER_W-1:0] act_p;
    logic [DIV_W-1:0] act_d;
    logic             act_vld;
    logic [PER_W-1:0] cur_p;
    logic [DIV_W-1:0] cur_d;
    logic [PER_W-1:0] per_cnt;
    logic [DIV_W-1:0] idx;
    logic [PER_W-1:0] prime_cnt;

    logic [PROD_W-1:0] prod;
    logic              cfg_ok;
    logic              accept;
    logic              last_idx;
    logic              wrap;
    logic              frame_wrap;
    logic              bnd_hit;
    logic              start;
    logic              apply;
    logic [PER_W-1:0]  run_per;
    logic [DIV_W-1:0]  run_idx;
    logic [PER_W-1:0]  nxt_p;
    logic [DIV_W-1:0]  nxt_d;
    logic              run_sh;
    logic              run_icg;

    tcd1304_fm_div #(.CLK_DIV(CLK_DIV)) u_fm_div (
        .clk     (clk),
        .rst     (rst),
        .clk_2m  (clk_2m),
        .fm_tick (fm_tick)
    );

    assign cfg_ready = ~pend_vld;
    assign accept    = cfg_valid & cfg_ready;
    assign prod      = PROD_W'(cfg_sh_period) * PROD_W'(cfg_icg_div);
    assign cfg_ok    = (cfg_sh_period >= PER_W'(MIN_PER)) && (cfg_icg_div != '0)
                    && (prod >= PROD_W'(MIN_FRAME));

    assign last_idx   = (idx == cur_d - DIV_W'(1));
    assign wrap       = (per_cnt == cur_p - PER_W'(1));
    assign frame_wrap = wrap & last_idx;
    // Boundary is the tick that moves per_cnt onto P-ICG_LEAD in the last pulse, i.e. where ICG falls
    assign bnd_hit    = (state == ST_RUN) && fm_tick && last_idx
                     && (per_cnt == cur_p - PER_W'(ICG_LEAD + 1));
    assign start      = (state == ST_IDLE) && fm_tick && enable && (pend_vld || act_vld);
    assign apply      = pend_vld && (start || (bnd_hit && enable));

    always_comb begin
        run_per = wrap ? '0 : per_cnt + PER_W'(1);
        run_idx = idx;
        if (wrap)
            run_idx = last_idx ? '0 : idx + DIV_W'(1);
        nxt_p   = frame_wrap ? act_p : cur_p;
        nxt_d   = frame_wrap ? act_d : cur_d;
        run_sh  = (run_per < PER_W'(SH_WIDTH));
        run_icg = !(((run_idx == '0) && (run_per < PER_W'(SH_WIDTH + ICG_TRAIL)))
                 || ((run_idx == nxt_d - DIV_W'(1)) && (run_per >= nxt_p - PER_W'(ICG_LEAD))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pend         <= '0;
            pend_vld     <= 1'b0;
            act_p        <= '0;
            act_d        <= '0;
            act_vld      <= 1'b0;
            cur_p        <= '0;
            cur_d        <= '0;
            per_cnt      <= '0;
            idx          <= '0;
            prime_cnt    <= '0;
            cfg_err      <= 1'b0;
            tcd1304_sh   <= 1'b0;
            tcd1304_icg  <= 1'b1;
            tcd1304_load <= 1'b0;
            sync_phase   <= 2'd0;
            frame_start  <= 1'b0;
        end else begin
            cfg_err      <= accept & ~cfg_ok;
            tcd1304_load <= start | apply;
            frame_start  <= 1'b0;

            if (accept && cfg_ok) begin
                pend.period  <= cfg_sh_period;
                pend.icg_div <= cfg_icg_div;
                pend.phase   <= cfg_sync_phase;
                pend_vld     <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end

            // Applied config waits in act_* until the running frame wraps
            if (apply) begin
                act_p      <= pend.period;
                act_d      <= pend.icg_div;
                act_vld    <= 1'b1;
                sync_phase <= pend.phase;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_PRIME;
                        prime_cnt   <= '0;
                        tcd1304_icg <= 1'b0;
                        cur_p       <= pend_vld ? pend.period  : act_p;
                        cur_d       <= pend_vld ? pend.icg_div : act_d;
                    end
                end
                ST_PRIME: begin
                    if (fm_tick) begin
                        if (prime_cnt == PER_W'(ICG_LEAD - 1)) begin
                            state       <= ST_RUN;
                            per_cnt     <= '0;
                            idx         <= '0;
                            tcd1304_sh  <= 1'b1;
                            frame_start <= 1'b1;
                        end else begin
                            prime_cnt <= prime_cnt + PER_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (fm_tick) begin
                        if (bnd_hit && !enable) begin
                            state       <= ST_IDLE;
                            tcd1304_sh  <= 1'b0;
                            tcd1304_icg <= 1'b1;
                        end else begin
                            per_cnt     <= run_per;
                            idx         <= run_idx;
                            cur_p       <= nxt_p;
                            cur_d       <= nxt_d;
                            tcd1304_sh  <= run_sh;
                            tcd1304_icg <= run_icg;
                            frame_start <= frame_wrap;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcd1304_timing_gen.sv
// Bench for tcd1304_timing_gen at a scaled-down fM divider and frame minimum.
module tb_tcd1304_timing_gen;

    localparam int CLK_DIV = 4;
    localparam int MINF    = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] cfg_sh_period = '0;
    logic [7:0]  cfg_icg_div = '0;
    logic [1:0]  cfg_sync_phase = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, cfg_err, clk_2m, tcd1304_sh, tcd1304_icg, tcd1304_load, frame_start;
    logic [1:0]  sync_phase;

    tcd1304_timing_gen #(
        .CLK_DIV(CLK_DIV), .SH_WIDTH(4), .ICG_LEAD(1), .ICG_TRAIL(2), .MIN_FRAME(MINF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_sh_period(cfg_sh_period), .cfg_icg_div(cfg_icg_div), .cfg_sync_phase(cfg_sync_phase),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_2m(clk_2m), .tcd1304_sh(tcd1304_sh), .tcd1304_icg(tcd1304_icg),
        .tcd1304_load(tcd1304_load), .sync_phase(sync_phase), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected sync_phase values, one per expected load pulse
    int exp_phase_q[$];
    int load_t_q[$], sh_rise_q[$], sh_fall_q[$], icg_fall_q[$], icg_rise_q[$], fs_q[$];
    logic p_sh = 1'b0, p_icg = 1'b1, p_c2m = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tcd1304_load) begin
                load_t_q.push_back(cyc);
                check("load_with_icg_low", int'(tcd1304_icg), 0);
                if (exp_phase_q.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    check("load_sync_phase", int'(sync_phase), exp_phase_q.pop_front());
                end
            end
            if (tcd1304_sh && !p_sh) begin
                sh_rise_q.push_back(cyc);
                check("sh_rise_on_fm_rise", int'(clk_2m && !p_c2m), 1);
            end
            if (!tcd1304_sh && p_sh) sh_fall_q.push_back(cyc);
            if (!tcd1304_icg && p_icg) icg_fall_q.push_back(cyc);
            if (tcd1304_icg && !p_icg) icg_rise_q.push_back(cyc);
            if (frame_start) fs_q.push_back(cyc);
        end
        p_sh = tcd1304_sh;
        p_icg = tcd1304_icg;
        p_c2m = clk_2m;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        load_t_q.delete(); sh_rise_q.delete(); sh_fall_q.delete();
        icg_fall_q.delete(); icg_rise_q.delete(); fs_q.delete();
    endtask

    task automatic offer(input int p, input int d, input int ph);
        cfg_sh_period  = 20'(p);
        cfg_icg_div    = 8'(d);
        cfg_sync_phase = 2'(ph);
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk_2m"}, int'(clk_2m), 0);
        check({tag, "_sh"}, int'(tcd1304_sh), 0);
        check({tag, "_icg"}, int'(tcd1304_icg), 1);
        check({tag, "_load"}, int'(tcd1304_load), 0);
        check({tag, "_sync_phase"}, int'(sync_phase), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
        check({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    endtask

    typedef struct {
        int p;
        int d;
        int ph;
        bit err;
    } vec_t;

    vec_t vecs[8];

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int f;
        int tl;
        vecs[0] = '{8, 5, 0, 1'b0};
        vecs[1] = '{7, 10, 1, 1'b1};
        vecs[2] = '{10, 0, 2, 1'b1};
        vecs[3] = '{8, 4, 3, 1'b1};
        vecs[4] = '{20, 2, 1, 1'b0};
        vecs[5] = '{19, 2, 0, 1'b1};
        vecs[6] = '{1048575, 255, 3, 1'b0};
        vecs[7] = '{0, 255, 2, 1'b1};

        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");

        // Config validation table, reset before each so the pending slot starts empty
        foreach (vecs[i]) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            offer(vecs[i].p, vecs[i].d, vecs[i].ph);
            check($sformatf("vec%0d_cfg_err", i), int'(cfg_err), int'(vecs[i].err));
            check($sformatf("vec%0d_cfg_ready", i), int'(cfg_ready), int'(vecs[i].err));
            tick();
            check($sformatf("vec%0d_err_pulse", i), int'(cfg_err), 0);
            check($sformatf("vec%0d_no_load", i), int'(load_t_q.size()), 0);
        end

        // Cold start: P=40, D=1, phase 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_q();
        enable = 1'b1;
        exp_phase_q.push_back(2);
        offer(40, 1, 2);
        for (int i = 0; i < 600 && fs_q.size() < 2; i++) tick();
        tl = (load_t_q.size() > 0) ? load_t_q[0] : -1000;
        check("cold_sh_after_load", (sh_rise_q.size() > 0) ? sh_rise_q[0] - tl : -1, CLK_DIV);
        check("cold_sh_width", (sh_fall_q.size() > 0 && sh_rise_q.size() > 0) ? sh_fall_q[0] - sh_rise_q[0] : -1, 4 * CLK_DIV);
        check("cold_icg_trail", (icg_rise_q.size() > 0 && sh_fall_q.size() > 0) ? icg_rise_q[0] - sh_fall_q[0] : -1, 2 * CLK_DIV);
        check("cold_frame_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 40 * CLK_DIV);
        check("cold_sync_phase", int'(sync_phase), 2);

        // Mid-frame config change to P=10, D=4, phase 1
        clear_q();
        for (int i = 0; i < 400 && fs_q.size() < 1; i++) tick();
        f = (fs_q.size() > 0) ? fs_q[0] : -1000;
        clear_q();
        exp_phase_q.push_back(1);
        offer(10, 4, 1);
        check("mid_ready_low", int'(cfg_ready), 0);
        for (int i = 0; i < 400 && load_t_q.size() < 1; i++) tick();
        tl = (load_t_q.size() > 0) ? load_t_q[0] : -1000;
        check("mid_load_at_boundary", tl - f, 39 * CLK_DIV);
        check("mid_old_sh_fall", (sh_fall_q.size() == 1) ? sh_fall_q[0] - f : -1, 4 * CLK_DIV);
        check("mid_old_no_extra_sh", int'(sh_rise_q.size()), 0);
        check("mid_ready_high", int'(cfg_ready), 1);
        clear_q();
        for (int i = 0; i < 600 && fs_q.size() < 2; i++) tick();
        check("mid_new_frame_start", (fs_q.size() > 0) ? fs_q[0] - tl : -1, CLK_DIV);
        check("mid_new_frame_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 40 * CLK_DIV);
        check("mid_sh_count", int'(sh_rise_q.size()), 5);
        check("mid_sh_period", (sh_rise_q.size() >= 2) ? sh_rise_q[1] - sh_rise_q[0] : -1, 10 * CLK_DIV);
        check("mid_icg_once", int'(icg_fall_q.size()), 1);

        // Rejected config while running leaves everything alone
        offer(8, 4, 3);
        check("run_bad_cfg_err", int'(cfg_err), 1);
        check("run_bad_cfg_ready", int'(cfg_ready), 1);
        clear_q();
        for (int i = 0; i < 200 && sh_rise_q.size() < 2; i++) tick();
        check("run_bad_sh_period", (sh_rise_q.size() >= 2) ? sh_rise_q[1] - sh_rise_q[0] : -1, 10 * CLK_DIV);
        check("run_bad_phase", int'(sync_phase), 1);

        // Disable mid-frame: frame completes, then idle levels
        clear_q();
        for (int i = 0; i < 400 && fs_q.size() < 1; i++) tick();
        clear_q();
        enable = 1'b0;
        repeat (300) tick();
        check("dis_sh_rises", int'(sh_rise_q.size()), 3);
        check("dis_icg_no_fall", int'(icg_fall_q.size()), 0);
        check("dis_icg_idle", int'(tcd1304_icg), 1);
        check("dis_sh_idle", int'(tcd1304_sh), 0);

        // Re-enable restarts with the same active config
        clear_q();
        exp_phase_q.push_back(1);
        enable = 1'b1;
        for (int i = 0; i < 300 && sh_rise_q.size() < 2; i++) tick();
        tl = (load_t_q.size() > 0) ? load_t_q[0] : -1000;
        check("reen_sh_after_load", (sh_rise_q.size() > 0) ? sh_rise_q[0] - tl : -1, CLK_DIV);
        check("reen_sh_period", (sh_rise_q.size() >= 2) ? sh_rise_q[1] - sh_rise_q[0] : -1, 10 * CLK_DIV);

        // Reset during PRIME
        enable = 1'b0;
        repeat (300) tick();
        exp_phase_q.push_back(1);
        enable = 1'b1;
        for (int i = 0; i < 100 && !tcd1304_load; i++) tick();
        check("prime_seen_load", int'(tcd1304_load), 1);
        rst = 1'b1;
        tick();
        check_reset_vals("prime_rst");
        rst = 1'b0;
        clear_q();
        repeat (300) tick();
        check("post_rst_no_load", int'(load_t_q.size()), 0);
        check("post_rst_no_sh", int'(sh_rise_q.size()), 0);
        check("post_rst_icg_idle", int'(tcd1304_icg), 1);
        check("scoreboard_drained", int'(exp_phase_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcd1304_timing_gen.md
# tcd1304_timing_gen

Generates the TCD1304 linear-CCD drive timing: the fM master clock (`clk_2m`), the SH shutter pulses and the ICG frame gate. It takes integration and frame configuration through a valid/ready handshake and applies new settings only at frame boundaries. On every start and every configuration change it pulses `tcd1304_load` and presents `sync_phase`, which re-arm the downstream `ads8556_syncn` multichip-sync stage.

## Interface
- `CLK_DIV`, 50: system clocks per fM period; even, ≥4. 100 MHz / 50 = 2 MHz.
- `SH_WIDTH`, 4: length of SH high, in fM cycles.
- `ICG_LEAD`, 1: ICG low before the frame SH rise, in fM cycles; ≥1.
- `ICG_TRAIL`, 2: ICG low after the frame SH fall, in fM cycles; ≥1.
- `MIN_FRAME`, 14776: minimum ICG period in fM cycles (3694 elements × 4).

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: run request.
- `cfg_sh_period` in 20: SH period in fM cycles.
- `cfg_icg_div` in 8: number of SH pulses per ICG frame.
- `cfg_sync_phase` in 2: ADC sync phase, forwarded downstream.
- `cfg_valid` in 1 / `cfg_ready` out 1: configuration handshake.
- `cfg_err` out 1: one-cycle pulse when an offered configuration is rejected.
- `clk_2m` out 1: fM clock, 50% duty.
- `tcd1304_sh` out 1: SH.
- `tcd1304_icg` out 1: ICG; idle level is high.
- `tcd1304_load` out 1: one-cycle pulse when a configuration is applied or a run starts.
- `sync_phase` out 2: applied phase; stable between loads.
- `frame_start` out 1: one-cycle pulse at the SH rise of pulse index 0.

## Operation
- **fM divider.** `div_cnt` counts 0..CLK_DIV-1. `clk_2m` is high while `div_cnt` < CLK_DIV/2. `fm_tick` fires at `div_cnt` = CLK_DIV-1. All SH/ICG state advances on `fm_tick` only.
- **Config handshake.**
  - `cfg_ready` = pending slot empty.
  - On `cfg_valid` & `cfg_ready`, the offered config is checked. It is valid only if all of the following hold:
    - `cfg_sh_period` ≥ SH_WIDTH + ICG_LEAD + ICG_TRAIL + 1;
    - `cfg_icg_div` ≥ 1;
    - `cfg_sh_period` × `cfg_icg_div` ≥ MIN_FRAME, computed as a 28-bit product.
  - A valid config is stored in the pending slot. An invalid one pulses `cfg_err` and is not stored.
- **Counters.**
  - `per_cnt` counts fM ticks 0..P-1, where P is the active period.
  - `idx` counts pulses 0..D-1, where D is the active ICG divider.
  - SH is high when `per_cnt` < SH_WIDTH.
  - ICG is low when (`idx`=0 & `per_cnt` < SH_WIDTH+ICG_TRAIL) or (`idx`=D-1 & `per_cnt` ≥ P-ICG_LEAD).
- **Frame boundary.** The boundary is the tick on which ICG falls, at `idx`=D-1, `per_cnt`=P-ICG_LEAD. At that tick:
  - if a pending config exists, it becomes active, `sync_phase` updates, `tcd1304_load` pulses, and the pending slot clears;
  - the new P and D take effect from the next `idx`=0.
- **FSM states:**
  - IDLE: sh=0, icg=1. Leaves to PRIME on `fm_tick` when `enable` & (pending or active_valid). A pending config is applied first. `tcd1304_load` pulses on every start.
  - PRIME: icg=0 for ICG_LEAD ticks, then RUN with `per_cnt`=0, `idx`=0.
  - RUN: counter-driven, as above. If `enable`=0 at a frame boundary, go to IDLE; ICG does not fall.
- **Simultaneous events.** A handshake on the same cycle as a boundary apply is accepted into the freshly emptied slot. `enable` is sampled only in IDLE and at boundaries.

## Timing
- All outputs are registered. `clk_2m` rises, and SH/ICG change, on the `clk` edge after `fm_tick`, so SH/ICG edges coincide with `clk_2m` rising edges.
- `tcd1304_load` and the `sync_phase` update share the edge on which ICG falls. SH then rises ICG_LEAD×CLK_DIV clocks later, so downstream sees load before `sh_rise`.
- `cfg_err` is asserted 1 cycle after the handshake. `cfg_ready` falls 1 cycle after an accepted valid config.
- Reset values: `clk_2m`=0, `tcd1304_sh`=0, `tcd1304_icg`=1, `tcd1304_load`=0, `sync_phase`=0, `frame_start`=0, `cfg_err`=0, `cfg_ready`=1.
- Reset also clears the active and pending configs and puts the FSM in IDLE. A reset mid-frame takes effect on the next edge, with no partial pulse.

## Structure
- Package `tcd1304_pkg`: FSM state enum (IDLE, PRIME, RUN), default parameter values, the MIN_FRAME constant, and the counter widths (PER_W=20, DIV_W=8).
- Sub-module `tcd1304_fm_div`: divider producing `clk_2m` and `fm_tick`. Everything else lives in one module.

## Test plan
- Cold start: reset, then config (14776, 1, phase 2) with `enable`=1.
  - `tcd1304_load` pulses with ICG falling and `sync_phase`=2.
  - SH rises 50 clocks later and stays high 200 clocks; ICG rises 100 clocks after SH falls.
  - `frame_start` period is 738800 clocks.
- Config (2000, 8) → 8 SH pulses 100000 clocks apart per ICG frame; ICG is low once per 16000 fM cycles.
- Config (1000, 4) → product 4000 < MIN_FRAME, so `cfg_err` pulses once, `cfg_ready` stays 1, and there is no load and no output change.
- New config accepted mid-frame:
  - `cfg_ready`=0 until the next ICG fall;
  - load and phase update occur there;
  - the new period starts at the next `idx`=0;
  - the old frame is undisturbed.
- `enable`→0 mid-frame → the frame completes, then ICG stays 1 and SH stays 0. Re-enable → PRIME, a load pulse, and the same active config.
- `rst` during PRIME → outputs return to reset values next cycle. A subsequent `enable` without a new config stays in IDLE.
